// File: rtl/segment_display_multi.sv
// Multiplexed seven-segment driver: binary value -> BCD (iterative shift-add-3) -> scanned digits.
// Latency: display outputs reflect a new value IN_WIDTH+2 clocks after value_valid is accepted.
// Backpressure: busy=1 during conversion; value_valid pulses seen while busy are dropped, not queued.
module segment_display_multi #(
    parameter int DIGITS         = 4,
    parameter int IN_WIDTH       = 14,
    parameter int REFRESH_BITS   = 18,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic                clock_100Mhz,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] value,
    input  logic                value_valid,
    output logic                busy,
    input  logic                blank_en,
    input  logic [DIGITS-1:0]   dp_mask,
    output logic [DIGITS-1:0]   Anode_Activate,
    output logic [6:0]          LED_out,
    output logic                LED_dp,
    output logic                overflow
);

    // Scratch BCD must hold 2^IN_WIDTH-1, and always keeps at least one nibble
    // above the displayed digits so the overflow test has something to look at.
    localparam int NIB_MIN = (IN_WIDTH + 5) / 3;
    localparam int NIB     = (NIB_MIN > DIGITS) ? NIB_MIN : DIGITS + 1;
    localparam int BCD_W   = NIB * 4;
    localparam int DISP_W  = DIGITS * 4;
    localparam int IDX_W   = $clog2(DIGITS);
    localparam int CNT_W   = $clog2(IN_WIDTH + 1);

    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

    localparam logic [6:0] SEG_DASH = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [IN_WIDTH-1:0] shreg;
    logic [BCD_W-1:0]    bcd;
    logic [BCD_W-1:0]    bcd_adj;
    logic [CNT_W-1:0]    shift_cnt;
    logic [DISP_W-1:0]   disp;

    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [IDX_W-1:0]        scan_idx;

    logic [3:0]        nib [DIGITS];
    logic [DIGITS-1:0] lead_zero;
    logic [3:0]        cur_nib;
    logic [6:0]        seg_raw;
    logic [DIGITS-1:0] an_raw;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0100111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Add-3 correction on every scratch nibble that is 5 or more, ahead of the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NIB; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Converter FSM; the displayed register only changes in DONE so the display never glitches.
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            shreg     <= '0;
            bcd       <= '0;
            shift_cnt <= '0;
            disp      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (value_valid) begin
                        shreg     <= value;
                        bcd       <= '0;
                        shift_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd       <= {bcd_adj[BCD_W-2:0], shreg[IN_WIDTH-1]};
                    shreg     <= shreg << 1;
                    shift_cnt <= shift_cnt + 1'b1;
                    if (shift_cnt == CNT_W'(IN_WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    disp     <= bcd[DISP_W-1:0];
                    overflow <= |bcd[BCD_W-1:DISP_W];
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Free-running refresh counter; scan index steps down on each wrap, from 0 back to the top digit.
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= '0;
            scan_idx    <= IDX_W'(DIGITS - 1);
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
            if (&refresh_cnt) begin
                if (scan_idx == '0) begin
                    scan_idx <= IDX_W'(DIGITS - 1);
                end else begin
                    scan_idx <= scan_idx - 1'b1;
                end
            end
        end
    end

    // Split the displayed BCD into digits and flag runs of zeros from the most significant end.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            nib[i] = disp[i*4 +: 4];
        end
        lead_zero = '0;
        lead_zero[DIGITS-1] = (nib[DIGITS-1] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            lead_zero[i] = lead_zero[i+1] && (nib[i] == 4'd0);
        end
    end

    // Segment pattern and anode select for the digit currently being scanned.
    always_comb begin
        cur_nib = nib[scan_idx];
        an_raw  = DIGITS'(1) << scan_idx;
        if (overflow) begin
            seg_raw = SEG_DASH;
        end else if (blank_en && (scan_idx != '0) && lead_zero[scan_idx]) begin
            seg_raw = 7'b0000000;
        end else begin
            seg_raw = seg_decode(cur_nib);
        end
    end

    // Registered pin drivers with polarity applied; reset parks every pin at its inactive level.
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            Anode_Activate <= {DIGITS{AN_INV}};
            LED_out        <= {7{SEG_INV}};
            LED_dp         <= SEG_INV;
        end else begin
            Anode_Activate <= an_raw ^ {DIGITS{AN_INV}};
            LED_out        <= seg_raw ^ {7{SEG_INV}};
            LED_dp         <= dp_mask[scan_idx] ^ SEG_INV;
        end
    end

endmodule
